// File: rtl/keypad_pkg.sv
// Keypad scanner shared types: FSM states, scan-result codes,
// default matrix geometry and key-code width.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } kp_state_e;

  // Values equal the saturated key count of one scan.
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_res_e;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KEY_W   = $clog2(KP_ROWS * KP_COLS);

  function automatic logic [1:0] sat_add2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column walker: holds each column low for SCAN_DIV cycles and
// flags the row-sample slot and the end of a full scan.
module keypad_col_driver #(
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  localparam int IW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [COLS-1:0] col_n,
  output logic [IW-1:0] col_idx,
  output logic          sample,
  output logic          scan_done
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] slot_cnt;

  assign sample    = (slot_cnt == CW'(SCAN_DIV - 1));
  assign scan_done = sample && (col_idx == IW'(COLS - 1));
  assign col_n     = ~(COLS'(1) << col_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= '0;
    end else if (sample) begin
      slot_cnt <= '0;
      col_idx  <= scan_done ? '0 : col_idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: synchronizes rows, tallies each full scan
// and debounces press/release over whole-scan agreement.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = KP_ROWS,
  parameter int COLS     = KP_COLS,
  parameter int SCAN_DIV = 50000,
  parameter int DB_SCANS = 4,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_down
);

  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(DB_SCANS + 1);

  logic [IW-1:0]   col_idx;
  logic            sample;
  logic            scan_done;
  logic [ROWS-1:0] row_s1;
  logic [ROWS-1:0] row_s2;

  keypad_col_driver #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_col (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .col_idx   (col_idx),
    .sample    (sample),
    .scan_done (scan_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  logic [1:0]    col_hits;
  logic [RW-1:0] col_row;
  logic [KW-1:0] cur_code;
  logic [1:0]    nkeys;
  logic [KW-1:0] cand;
  logic [1:0]    tot;
  logic [KW-1:0] scan_cand;
  scan_res_e     res;

  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2[r]) begin
        col_hits = sat_add2(col_hits, 2'd1);
        col_row  = RW'(r);
      end
    end
  end

  assign cur_code  = KW'(int'(col_row) * COLS + int'(col_idx));
  assign tot       = sat_add2(nkeys, col_hits);
  assign scan_cand = (col_hits != 2'd0) ? cur_code : cand;
  assign res       = scan_res_e'(tot);

  always_ff @(posedge clk) begin
    if (rst || (sample && scan_done)) begin
      nkeys <= '0;
      cand  <= '0;
    end else if (sample) begin
      nkeys <= tot;
      cand  <= scan_cand;
    end
  end

  kp_state_e     state, state_n;
  logic [DW-1:0] dbcnt, dbcnt_n;
  logic [KW-1:0] hold, hold_n;
  logic          fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dbcnt     <= '0;
      hold      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      dbcnt     <= dbcnt_n;
      hold      <= hold_n;
      key_valid <= fire;
      if (fire) key_code <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    dbcnt_n = dbcnt;
    hold_n  = hold;
    fire    = 1'b0;
    if (scan_done) begin
      case (state)
        S_IDLE: begin
          if (res == SCAN_SINGLE) begin
            hold_n = scan_cand;
            if (DB_SCANS <= 1) begin
              state_n = S_PRESSED;
              dbcnt_n = '0;
              fire    = 1'b1;
            end else begin
              state_n = S_DEBOUNCE;
              dbcnt_n = DW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (res == SCAN_SINGLE && scan_cand == hold) begin
            if (dbcnt == DW'(DB_SCANS - 1)) begin
              state_n = S_PRESSED;
              dbcnt_n = '0;
              fire    = 1'b1;
            end else begin
              dbcnt_n = dbcnt + DW'(1);
            end
          end else begin
            state_n = S_IDLE;
            dbcnt_n = '0;
          end
        end
        S_PRESSED: begin
          // Ghost/multi-key patterns while held are ignored.
          if (res == SCAN_NONE) begin
            if (DB_SCANS <= 1) begin
              state_n = S_IDLE;
              dbcnt_n = '0;
            end else begin
              state_n = S_RELEASE;
              dbcnt_n = DW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (res == SCAN_NONE) begin
            if (dbcnt == DW'(DB_SCANS - 1)) begin
              state_n = S_IDLE;
              dbcnt_n = '0;
            end else begin
              dbcnt_n = dbcnt + DW'(1);
            end
          end else begin
            state_n = S_PRESSED;
            dbcnt_n = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
          dbcnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_down = (state == S_PRESSED) || (state == S_RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed checks of keypad_scanner against a
// scan-level model of the debounce rules on a 4x4 matrix.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] key_map = '0;

  int n_vec = 0;
  int n_err = 0;

  int m_streak;
  int m_rel;
  int m_hold;
  int m_code;
  bit m_down;
  bit m_pulse;

  keypad_scanner #(
    .ROWS     (4),
    .COLS     (4),
    .SCAN_DIV (SD),
    .DB_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(key_map[r*4 +: 4] & ~col_n);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_rel    = 0;
    m_hold   = 0;
    m_code   = 0;
    m_down   = 0;
    m_pulse  = 0;
  endtask

  task automatic model_scan();
    int n;
    int cand;
    n    = 0;
    cand = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (key_map[r*4 + c]) begin
          n++;
          cand = r * 4 + c;
        end
    m_pulse = 0;
    if (!m_down) begin
      if (n == 1 && m_streak == 0) begin
        m_streak = 1;
        m_hold   = cand;
      end else if (n == 1 && cand == m_hold) begin
        m_streak++;
      end else begin
        m_streak = 0;
      end
      if (m_streak == DB) begin
        m_down   = 1;
        m_code   = m_hold;
        m_pulse  = 1;
        m_streak = 0;
        m_rel    = 0;
      end
    end else begin
      m_rel = (n == 0) ? m_rel + 1 : 0;
      if (m_rel == DB) begin
        m_down = 0;
        m_rel  = 0;
      end
    end
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    model_reset();
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_down", key_down, 0);
    rst = 1'b0;
  endtask

  task automatic run_scan();
    logic [3:0] ec;
    for (int i = 0; i < SCAN; i++) begin
      ec = ~(4'b0001 << (i / SD));
      chk("col_n", col_n, ec);
      chk("key_valid", key_valid, (i == 0) && m_pulse);
      @(posedge clk);
      #1;
    end
    model_scan();
    chk("key_down", key_down, m_down);
    chk("key_code", key_code, m_code);
  endtask

  task automatic scans(input logic [15:0] km, input int n);
    key_map = km;
    for (int s = 0; s < n; s++) run_scan();
  endtask

  int pick;
  logic [15:0] km;

  initial begin
    model_reset();
    do_reset(3);

    scans(16'h0000, 1);
    scans(16'h0040, 6);
    scans(16'h0000, 4);

    for (int s = 0; s < 10; s++)
      scans(((s / 2) % 2 == 0) ? 16'h0020 : 16'h0000, 1);
    scans(16'h0000, 1);

    scans(16'h8001, 5);
    scans(16'h0000, 1);

    scans(16'h0200, 4);
    scans(16'h0000, 1);
    scans(16'h0200, 2);
    scans(16'h0000, 3);

    scans(16'h0040, 2);
    do_reset(1);
    scans(16'h0040, 4);
    scans(16'h0000, 3);

    km = '0;
    for (int s = 0; s < 80; s++) begin
      pick = $urandom_range(0, 9);
      if (pick >= 4 && pick <= 5)
        km = '0;
      else if (pick >= 6 && pick <= 8)
        km = 16'h0001 << $urandom_range(0, 15);
      else if (pick == 9)
        km = (16'h0001 << $urandom_range(0, 15)) |
             (16'h0001 << $urandom_range(0, 15));
      scans(km, 1);
    end

    chk("key_valid_last", key_valid, m_pulse);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
